adc_conditioner: RTL

ADC_CONDITIONER -- requirements
Module: adc_conditioner

---
 rtl/adc_conditioner.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/adc_conditioner.sv
// adc_conditioner: samples the accel pedal and light sensor ADC codes on a
//    periodic tick, filters them, maps accel to throttle percent and derives a
//    debounced day/night flag.
// Latency: outputs and sample_valid appear 3 clocks after the capture edge.
// Backpressure: none; the tick is free-running and results hold until the next pulse.
//
// Ports:
//    clk, rst            single clock; synchronous active-high reset
//    adc_accel, adc_cds  quasi-static 8-bit ADC codes (no strobe)
//    accel_filt,cds_filt filtered codes
//    throttle_pct        0..100 throttle request
//    night_mode          1 = dark, headlights requested
//    sample_valid        one-clock strobe, all outputs refreshed together
//
// Build option: define ADC_CONDITIONER_FILTER_EN for the 8-tap moving average.
// Without it the filtered outputs carry the raw captured samples; FSM timing
// is identical either way.
module adc_conditioner #(
   parameter int SAMPLE_DIV = 50000,
   parameter int DEADZONE   = 16,
   parameter int ACCEL_MAX  = 250,
   parameter int NIGHT_ON   = 60,
   parameter int NIGHT_OFF  = 90,
   parameter int DEBOUNCE   = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] adc_accel,
   input  logic [7:0] adc_cds,
   output logic [7:0] accel_filt,
   output logic [7:0] cds_filt,
   output logic [6:0] throttle_pct,
   output logic       night_mode,
   output logic       sample_valid
);

   localparam int CNT_W = $clog2(SAMPLE_DIV);
   localparam int DB_W  = $clog2(DEBOUNCE + 1);

   localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(SAMPLE_DIV - 1);
   localparam logic [7:0]       DZ        = 8'(DEADZONE);
   localparam logic [7:0]       AMAX      = 8'(ACCEL_MAX);
   localparam logic [7:0]       N_ON      = 8'(NIGHT_ON);
   localparam logic [7:0]       N_OFF     = 8'(NIGHT_OFF);
   localparam logic [DB_W-1:0]  DB_MAX    = DB_W'(DEBOUNCE);

   typedef enum logic [1:0] {IDLE, CAPTURE, COMPUTE, UPDATE} state_t;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] tick_cnt;
   logic             tick;
   logic             capture_en;
   logic [7:0]       cap_accel, cap_cds;
   logic [7:0]       filt_accel, filt_cds;
   logic [14:0]      accel_x100;
   logic [6:0]       thr_calc, thr_q;
   logic [DB_W-1:0]  dark_cnt, light_cnt;

   // Free-running sample tick.
   assign tick = (tick_cnt == TICK_LAST);

   always_ff @(posedge clk) begin
      if (rst)       tick_cnt <= '0;
      else if (tick) tick_cnt <= '0;
      else           tick_cnt <= tick_cnt + CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (tick) state_nxt = CAPTURE;
         CAPTURE: state_nxt = COMPUTE;
         COMPUTE: state_nxt = UPDATE;
         UPDATE:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Both channels are latched on the edge that moves the FSM into CAPTURE,
   // so they always come from the same clock edge and stay stable until the
   // next tick.
   assign capture_en = (state == IDLE) && tick;

   always_ff @(posedge clk) begin
      if (rst) begin
         cap_accel <= '0;
         cap_cds   <= '0;
      end else if (capture_en) begin
         cap_accel <= adc_accel;
         cap_cds   <= adc_cds;
      end
   end

`ifdef ADC_CONDITIONER_FILTER_EN
   logic [7:0]  buf_accel [8];
   logic [7:0]  buf_cds   [8];
   logic [10:0] sum_accel, sum_cds;
   logic [2:0]  wr_ptr;
   logic        primed;

   // Running sum of the last 8 samples. The first sample after reset fills the
   // whole window so the average starts at that value instead of ramping from 0.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 8; i++) begin
            buf_accel[i] <= '0;
            buf_cds[i]   <= '0;
         end
         sum_accel <= '0;
         sum_cds   <= '0;
         wr_ptr    <= '0;
         primed    <= 1'b0;
      end else if (state == CAPTURE) begin
         if (!primed) begin
            for (int i = 0; i < 8; i++) begin
               buf_accel[i] <= cap_accel;
               buf_cds[i]   <= cap_cds;
            end
            sum_accel <= {cap_accel, 3'b000};
            sum_cds   <= {cap_cds, 3'b000};
            primed    <= 1'b1;
         end else begin
            sum_accel         <= sum_accel + {3'b000, cap_accel} - {3'b000, buf_accel[wr_ptr]};
            sum_cds           <= sum_cds + {3'b000, cap_cds} - {3'b000, buf_cds[wr_ptr]};
            buf_accel[wr_ptr] <= cap_accel;
            buf_cds[wr_ptr]   <= cap_cds;
            wr_ptr            <= wr_ptr + 3'd1;
         end
      end
   end

   assign filt_accel = sum_accel[10:3];
   assign filt_cds   = sum_cds[10:3];
`else
   assign filt_accel = cap_accel;
   assign filt_cds   = cap_cds;
`endif

   // filt*100 peaks at 25500, inside 15 bits; >>8 approximates /2.56.
   assign accel_x100 = {7'b0, filt_accel} * 15'd100;

   always_comb begin
      thr_calc = accel_x100[14:8];
      if (filt_accel <= DZ)        thr_calc = 7'd0;
      else if (filt_accel >= AMAX) thr_calc = 7'd100;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         thr_q     <= '0;
         dark_cnt  <= '0;
         light_cnt <= '0;
      end else if (state == COMPUTE) begin
         thr_q <= thr_calc;
         if (filt_cds < N_ON) begin
            dark_cnt  <= (dark_cnt == DB_MAX) ? DB_MAX : dark_cnt + DB_W'(1);
            light_cnt <= '0;
         end else if (filt_cds > N_OFF) begin
            light_cnt <= (light_cnt == DB_MAX) ? DB_MAX : light_cnt + DB_W'(1);
            dark_cnt  <= '0;
         end else begin
            dark_cnt  <= '0;
            light_cnt <= '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         accel_filt   <= '0;
         cds_filt     <= '0;
         throttle_pct <= '0;
         night_mode   <= 1'b0;
         sample_valid <= 1'b0;
      end else begin
         sample_valid <= 1'b0;
         if (state == UPDATE) begin
            accel_filt   <= filt_accel;
            cds_filt     <= filt_cds;
            throttle_pct <= thr_q;
            sample_valid <= 1'b1;
            if (dark_cnt == DB_MAX)       night_mode <= 1'b1;
            else if (light_cnt == DB_MAX) night_mode <= 1'b0;
         end
      end
   end

endmodule
